// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and helpers for the packet arbiter
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Round-robin increment: n-1 wraps back to 0
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin search starting at rr_ptr
module rr_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_BITS   = 2
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_BITS-1:0]   rr_ptr,
  output logic                  found,
  output logic [SEL_BITS-1:0]   sel
);

  int idx;

  // Walk rr_ptr, rr_ptr+1, ... (mod NUM_INPUTS); first requester wins
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = int'(rr_ptr);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = SEL_BITS'(idx);
      end
      idx = rr_next(idx, NUM_INPUTS);
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-atomic round-robin AXI-Stream arbiter (optional AXIS_PACKET_ARBITER_TDEST_EN adds axis_o_tdest)
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS     = 4,
  parameter  int AXIS_BYTES     = 1,
  parameter  int AXIS_USER_BITS = 1,
  localparam int SEL_BITS       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 areset,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                                 axis_o_tready,
  output logic                                 axis_o_tvalid,
  output logic                                 axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic                                 busy,
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
  output logic [SEL_BITS-1:0]                  axis_o_tdest,
`endif
  output logic [SEL_BITS-1:0]                  grant
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int UW = AXIS_USER_BITS;

  arb_state_t          state;
  arb_state_t          state_next;
  logic [SEL_BITS-1:0] grant_next;
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] rr_ptr_next;
  logic                req_found;
  logic [SEL_BITS-1:0] req_sel;
  logic                last_fire;

  rr_select #(
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_BITS  (SEL_BITS)
  ) u_rr_select (
    .req   (axis_i_tvalid),
    .rr_ptr(rr_ptr),
    .found (req_found),
    .sel   (req_sel)
  );

  assign last_fire = axis_o_tvalid && axis_o_tready && axis_o_tlast;

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Arbitrate only in IDLE; hold the grant until the tlast handshake
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (req_found) begin
          grant_next = req_sel;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (last_fire) begin
          state_next  = ARB_IDLE;
          rr_ptr_next = SEL_BITS'(rr_next(int'(grant), NUM_INPUTS));
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Datapath mux on the registered grant; handshakes only pass while BUSY
  always_comb begin
    busy          = (state == ARB_BUSY);
    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = axis_i_tdata[int'(grant)*DW +: DW];
    axis_o_tuser  = axis_i_tuser[int'(grant)*UW +: UW];
    if (state == ARB_BUSY) begin
      axis_o_tvalid        = axis_i_tvalid[grant];
      axis_o_tlast         = axis_i_tlast[grant];
      axis_i_tready[grant] = axis_o_tready;
    end
  end

`ifdef AXIS_PACKET_ARBITER_TDEST_EN
  assign axis_o_tdest = (state == ARB_BUSY) ? grant : '0;
`else
  // no tdest sideband in this build
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - directed self-checking bench for axis_packet_arbiter
module tb_axis_packet_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           areset;
  logic [N-1:0]   i_tready;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   i_tlast;
  logic [N*8-1:0] i_tdata;
  logic [N-1:0]   i_tuser;
  logic           o_tready;
  logic           o_tvalid;
  logic           o_tlast;
  logic [7:0]     o_tdata;
  logic [0:0]     o_tuser;
  logic           busy;
  logic [1:0]     grant;
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
  logic [1:0]     o_tdest;
`endif

  int         checks = 0;
  int         errors = 0;
  int         len[N];
  int         beat[N];
  int         left[N];
  logic [7:0] base[N];
  logic       hold[N];
  int         gseq2[6] = '{0, 1, 2, 3, 0, 1};
  int         gseq6[4] = '{0, 2, 0, 2};

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_INPUTS(N),
    .AXIS_BYTES(1),
    .AXIS_USER_BITS(1)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .axis_i_tready(i_tready),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tlast (i_tlast),
    .axis_i_tdata (i_tdata),
    .axis_i_tuser (i_tuser),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata),
    .axis_o_tuser (o_tuser),
    .busy         (busy),
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
    .axis_o_tdest (o_tdest),
`endif
    .grant        (grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int n = 0; n < N; n++) begin
      i_tvalid[n]         = (left[n] > 0) && !hold[n];
      i_tlast[n]          = (beat[n] == len[n] - 1);
      i_tdata[n*8 +: 8]   = base[n] + 8'(beat[n]);
      i_tuser[n]          = (beat[n] == 0);
    end
  endtask

  task automatic clear_src();
    for (int n = 0; n < N; n++) begin
      len[n]  = 1;
      beat[n] = 0;
      left[n] = 0;
      base[n] = 8'h00;
      hold[n] = 1'b0;
    end
    drive_src();
  endtask

  // Advance one clock; sources step on the handshakes seen at that edge
  task automatic tick();
    logic [N-1:0] fire;
    fire = i_tvalid & i_tready;
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin
      if (fire[n]) begin
        if (beat[n] == len[n] - 1) begin
          beat[n] = 0;
          left[n]--;
        end else begin
          beat[n]++;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    o_tready = 1'b1;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   32'(busy),     32'd0);
    check({tag, "_tvalid"}, 32'(o_tvalid), 32'd0);
    check({tag, "_tready"}, 32'(i_tready), 32'd0);
  endtask

  task automatic check_beat(input string tag, input int g, input logic [7:0] d,
                            input logic last, input logic user);
    check({tag, "_busy"},   32'(busy),     32'd1);
    check({tag, "_grant"},  32'(grant),    32'(g));
    check({tag, "_tvalid"}, 32'(o_tvalid), 32'd1);
    check({tag, "_tdata"},  32'(o_tdata),  32'(d));
    check({tag, "_tlast"},  32'(o_tlast),  32'(last));
    check({tag, "_tuser"},  32'(o_tuser),  32'(user));
    check({tag, "_tready"}, 32'(i_tready), 32'(1 << g));
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
    check({tag, "_tdest"},  32'(o_tdest),  32'(g));
`endif
  endtask

  initial begin
    areset   = 1'b1;
    o_tready = 1'b1;
    clear_src();
    #1;
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_grant",  32'(grant),    32'd0);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tready", 32'(i_tready), 32'd0);

    // 3-beat packet from input 0
    do_reset();
    len[0] = 3; left[0] = 1; base[0] = 8'hA1;
    drive_src(); #1;
    check_idle("t1_bubble");
    tick(); check_beat("t1_b0", 0, 8'hA1, 1'b0, 1'b1);
    tick(); check_beat("t1_b1", 0, 8'hA2, 1'b0, 1'b0);
    tick(); check_beat("t1_b2", 0, 8'hA3, 1'b1, 1'b0);
    tick(); check_idle("t1_end");

    // All inputs busy with 2-beat packets: strict rotation, 3 cycles each
    do_reset();
    for (int n = 0; n < N; n++) begin
      len[n] = 2; left[n] = 2; base[n] = 8'((n + 1) * 16);
    end
    drive_src(); #1;
    for (int k = 0; k < 6; k++) begin
      check_idle("t2_bubble");
      tick(); check_beat("t2_b0", gseq2[k], base[gseq2[k]],        1'b0, 1'b1);
      tick(); check_beat("t2_b1", gseq2[k], base[gseq2[k]] + 8'd1, 1'b1, 1'b0);
      tick();
    end

    // Single-beat grant to 1 moves rr_ptr to 2; then 1 and 3 contend
    do_reset();
    len[1] = 1; left[1] = 1; base[1] = 8'h51;
    drive_src(); #1;
    tick(); check_beat("t3_single", 1, 8'h51, 1'b1, 1'b1);
    tick(); check_idle("t3_single_end");
    left[1] = 1; len[3] = 1; left[3] = 1; base[3] = 8'h53;
    drive_src(); #1;
    tick(); check_beat("t3_first", 3, 8'h53, 1'b1, 1'b1);
    tick(); check_idle("t3_gap");
    tick(); check_beat("t3_second", 1, 8'h51, 1'b1, 1'b1);
    tick(); check_idle("t3_end");

    // Downstream backpressure and a source stall mid-packet
    do_reset();
    len[0] = 3; left[0] = 1; base[0] = 8'h60;
    len[1] = 2; left[1] = 1; base[1] = 8'h70;
    drive_src(); #1;
    tick(); check_beat("t4_b0", 0, 8'h60, 1'b0, 1'b1);
    tick(); check_beat("t4_b1", 0, 8'h61, 1'b0, 1'b0);
    o_tready = 1'b0; #1;
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_tdata",  32'(o_tdata),  32'h61);
      check("t4_hold_tvalid", 32'(o_tvalid), 32'd1);
      check("t4_hold_tready", 32'(i_tready), 32'd0);
      check("t4_hold_grant",  32'(grant),    32'd0);
      tick();
    end
    o_tready = 1'b1; #1;
    check_beat("t4_resume", 0, 8'h61, 1'b0, 1'b0);
    tick();
    hold[0] = 1'b1; drive_src(); #1;
    check("t4_stall_tvalid", 32'(o_tvalid), 32'd0);
    check("t4_stall_busy",   32'(busy),     32'd1);
    check("t4_stall_grant",  32'(grant),    32'd0);
    tick();
    hold[0] = 1'b0; drive_src(); #1;
    check_beat("t4_b2", 0, 8'h62, 1'b1, 1'b0);
    tick(); check_idle("t4_gap");
    tick(); check_beat("t4_next", 1, 8'h70, 1'b0, 1'b1);

    // Asynchronous reset during beat 2 of a 4-beat packet
    do_reset();
    len[1] = 1; left[1] = 1; base[1] = 8'h81;
    drive_src(); #1;
    tick(); check_beat("t5_pre", 1, 8'h81, 1'b1, 1'b1);
    tick(); check_idle("t5_pre_end");
    len[0] = 4; left[0] = 1; base[0] = 8'h90;
    drive_src(); #1;
    tick(); check_beat("t5_b0", 0, 8'h90, 1'b0, 1'b1);
    tick(); check_beat("t5_b1", 0, 8'h91, 1'b0, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    check("t5_async_tvalid", 32'(o_tvalid), 32'd0);
    check("t5_async_tready", 32'(i_tready), 32'd0);
    check("t5_async_busy",   32'(busy),     32'd0);
    check("t5_async_grant",  32'(grant),    32'd0);
    clear_src();
    @(posedge clk); #1;
    areset = 1'b0; #1;
    check_idle("t5_released");
    len[0] = 1; left[0] = 1; base[0] = 8'hA0;
    len[3] = 1; left[3] = 1; base[3] = 8'hB3;
    drive_src(); #1;
    tick(); check_beat("t5_after", 0, 8'hA0, 1'b1, 1'b1);
    tick(); check_idle("t5_after_gap");
    tick(); check_beat("t5_after2", 3, 8'hB3, 1'b1, 1'b1);

    // Inputs 2 and 0 alternate packets
    do_reset();
    len[0] = 2; left[0] = 2; base[0] = 8'hC0;
    len[2] = 2; left[2] = 2; base[2] = 8'hE0;
    drive_src(); #1;
    for (int k = 0; k < 4; k++) begin
      check_idle("t6_bubble");
      tick(); check_beat("t6_b0", gseq6[k], base[gseq6[k]],        1'b0, 1'b1);
      tick(); check_beat("t6_b1", gseq6[k], base[gseq6[k]] + 8'd1, 1'b1, 1'b0);
      tick();
    end
    check_idle("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
